// File: rtl/rf_wb_arbiter.sv
// Two-requester write-back arbiter sharing one register-file write port.
// Each requester has a small FIFO; a round-robin pick feeds a registered write stage.

module rf_wb_fifo #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [4:0]  push_addr,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic        ready,
  output logic        nonempty,
  output logic [4:0]  head_addr,
  output logic [31:0] head_data,
  output logic [31:0] pend
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [AW-1:0] offset;
  logic [4:0]    mem_addr [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses a push even when it pops on the same edge.
  assign ready     = (count != CW'(DEPTH));
  assign nonempty  = (count != '0);
  assign do_push   = push && ready;
  assign do_pop    = pop && nonempty;
  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; clearing count/pointers already makes every
  // slot invalid, so stale contents can never be popped or flagged busy.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pend   = '0;
    offset = '0;
    for (int j = 0; j < DEPTH; j++) begin
      offset = AW'(j) - rd_ptr;
      if (CW'(offset) < count) pend[mem_addr[j]] = 1'b1;
    end
  end
endmodule

module rf_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter bit ZERO_PROTECT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [31:0] busy
);
  typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_t;

  grant_t      last_grant;
  logic        a_nonempty, b_nonempty;
  logic        a_pop, b_pop;
  logic [4:0]  a_head_addr, b_head_addr;
  logic [31:0] a_head_data, b_head_data;
  logic [31:0] a_pend, b_pend;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (a_valid),
    .push_addr (a_addr),
    .push_data (a_data),
    .pop       (a_pop),
    .ready     (a_ready),
    .nonempty  (a_nonempty),
    .head_addr (a_head_addr),
    .head_data (a_head_data),
    .pend      (a_pend)
  );

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (b_valid),
    .push_addr (b_addr),
    .push_data (b_data),
    .pop       (b_pop),
    .ready     (b_ready),
    .nonempty  (b_nonempty),
    .head_addr (b_head_addr),
    .head_data (b_head_data),
    .pend      (b_pend)
  );

  // On a conflict the requester that did not win last time goes first.
  assign a_pop    = a_nonempty && (!b_nonempty || last_grant == GRANT_B);
  assign b_pop    = b_nonempty && !a_pop;
  assign sel_addr = a_pop ? a_head_addr : b_head_addr;
  assign sel_data = a_pop ? a_head_data : b_head_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_B;
    end else if (a_nonempty && b_nonempty) begin
      last_grant <= a_pop ? GRANT_A : GRANT_B;
    end
  end

  // Register-0 writes are drained like any other but never raise wr_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (a_pop || b_pop) begin
      wr_en   <= !(ZERO_PROTECT && sel_addr == 5'd0);
      wr_addr <= sel_addr;
      wr_data <= sel_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  always_comb begin
    busy = a_pend | b_pend;
    if (wr_en) busy[wr_addr] = 1'b1;
    if (ZERO_PROTECT) busy[0] = 1'b0;
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed vector table, hand-written
// reset/latency/zero-register sequences, then random traffic against a queue model.

module tb_rf_wb_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DEPTH(DEPTH), .ZERO_PROTECT(1'b1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: two queues, a fairness flag and the write-stage contents.
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        mq_a[$];
  ent_t        mq_b[$];
  bit          m_a_won_last;
  logic        m_wr_en;
  logic [4:0]  m_wr_addr;
  logic [31:0] m_wr_data;

  function automatic void model_reset();
    mq_a.delete();
    mq_b.delete();
    m_a_won_last = 1'b0;
    m_wr_en      = 1'b0;
    m_wr_addr    = '0;
    m_wr_data    = '0;
  endfunction

  function automatic void model_edge();
    bit   can_a = mq_a.size() < DEPTH;
    bit   can_b = mq_b.size() < DEPTH;
    bit   take_a;
    bit   have;
    ent_t w;
    have   = (mq_a.size() > 0) || (mq_b.size() > 0);
    take_a = (mq_a.size() > 0) && ((mq_b.size() == 0) || !m_a_won_last);
    if (mq_a.size() > 0 && mq_b.size() > 0) m_a_won_last = take_a;
    if (have) begin
      w = take_a ? mq_a.pop_front() : mq_b.pop_front();
      m_wr_en   = (w.addr != 5'd0);
      m_wr_addr = w.addr;
      m_wr_data = w.data;
    end else begin
      m_wr_en = 1'b0;
    end
    if (a_valid && can_a) mq_a.push_back('{addr: a_addr, data: a_data});
    if (b_valid && can_b) mq_b.push_back('{addr: b_addr, data: b_data});
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    foreach (mq_a[i]) b[mq_a[i].addr] = 1'b1;
    foreach (mq_b[i]) b[mq_b[i].addr] = 1'b1;
    if (m_wr_en) b[m_wr_addr] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".wr_en"},   wr_en,   m_wr_en);
    check({tag, ".wr_addr"}, wr_addr, m_wr_addr);
    check({tag, ".wr_data"}, wr_data, m_wr_data);
    check({tag, ".busy"},    busy,    model_busy());
    check({tag, ".a_ready"}, a_ready, mq_a.size() < DEPTH);
    check({tag, ".b_ready"}, b_ready, mq_b.size() < DEPTH);
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    @(negedge clk);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
  endtask

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic        bv;
    logic [4:0]  ba;
    logic        en;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ar;
    logic        br;
    logic [31:0] bz;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Both requesters push every cycle from reset; A data = A000_00xx, B data = B000_00xx.
    vecs[0] = '{1'b1, 5'd1, 1'b1, 5'd17, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 1'b1, 32'h0002_0002};
    vecs[1] = '{1'b1, 5'd2, 1'b1, 5'd18, 1'b1, 5'd1,  32'hA000_0001, 1'b1, 1'b0, 32'h0006_0006};
    vecs[2] = '{1'b1, 5'd3, 1'b1, 5'd19, 1'b1, 5'd17, 32'hB000_0011, 1'b0, 1'b1, 32'h0006_000C};
    vecs[3] = '{1'b1, 5'd4, 1'b1, 5'd19, 1'b1, 5'd2,  32'hA000_0002, 1'b1, 1'b0, 32'h000C_000C};
    vecs[4] = '{1'b1, 5'd4, 1'b1, 5'd20, 1'b1, 5'd18, 32'hB000_0012, 1'b0, 1'b1, 32'h000C_0018};
    vecs[5] = '{1'b1, 5'd5, 1'b1, 5'd20, 1'b1, 5'd3,  32'hA000_0003, 1'b1, 1'b0, 32'h0018_0018};
    vecs[6] = '{1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 5'd19, 32'hB000_0013, 1'b1, 1'b1, 32'h0018_0010};
    vecs[7] = '{1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 5'd4,  32'hA000_0004, 1'b1, 1'b1, 32'h0010_0010};
    vecs[8] = '{1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 5'd20, 32'hB000_0014, 1'b1, 1'b1, 32'h0010_0000};
    vecs[9] = '{1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 5'd20, 32'hB000_0014, 1'b1, 1'b1, 32'h0000_0000};

    model_reset();

    // Reset asserted with valids high: outputs clear at once and pushes are ignored.
    #2;
    a_valid = 1'b1; b_valid = 1'b1; a_addr = 5'd7; b_addr = 5'd8;
    rst_n = 1'b0;
    #1;
    check("rst.wr_en", wr_en, 1'b0);
    check("rst.busy", busy, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold.busy", busy, 32'h0);
    check("rst_hold.a_ready", a_ready, 1'b1);
    check("rst_hold.b_ready", b_ready, 1'b1);
    check("rst_hold.wr_en", wr_en, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;

    // Vector table: alternation 1,17,2,18,3,19 with backpressure at DEPTH entries.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].av, vecs[i].aa, 32'hA000_0000 | {27'd0, vecs[i].aa},
            vecs[i].bv, vecs[i].ba, 32'hB000_0000 | {27'd0, vecs[i].ba});
      step();
      check($sformatf("vec%0d.wr_en", i),   wr_en,   vecs[i].en);
      check($sformatf("vec%0d.wr_addr", i), wr_addr, vecs[i].wa);
      check($sformatf("vec%0d.wr_data", i), wr_data, vecs[i].wd);
      check($sformatf("vec%0d.a_ready", i), a_ready, vecs[i].ar);
      check($sformatf("vec%0d.b_ready", i), b_ready, vecs[i].br);
      check($sformatf("vec%0d.busy", i),    busy,    vecs[i].bz);
    end

    // Single write latency: busy from E0, wr_en exactly one cycle after E1.
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
    step();
    check("lat.e0.busy", busy, 32'h0000_0020);
    check("lat.e0.wr_en", wr_en, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    check("lat.e1.wr_en", wr_en, 1'b1);
    check("lat.e1.wr_addr", wr_addr, 5'd5);
    check("lat.e1.wr_data", wr_data, 32'hDEAD_BEEF);
    check("lat.e1.busy", busy, 32'h0000_0020);
    step();
    check("lat.e2.wr_en", wr_en, 1'b0);
    check("lat.e2.busy", busy, 32'h0);
    check("lat.e2.wr_data_hold", wr_data, 32'hDEAD_BEEF);

    // Lone A stream of 8: full rate, in order, never backpressured.
    for (int i = 0; i < 10; i++) begin
      drive(i < 8, 5'(8 + i), 32'h5000_0000 + 32'(i), 1'b0, 5'd0, 32'h0);
      step();
      check($sformatf("stream%0d.a_ready", i), a_ready, 1'b1);
      if (i >= 1 && i <= 8) begin
        check($sformatf("stream%0d.wr_en", i),   wr_en,   1'b1);
        check($sformatf("stream%0d.wr_addr", i), wr_addr, 5'(8 + i - 1));
        check($sformatf("stream%0d.wr_data", i), wr_data, 32'h5000_0000 + 32'(i - 1));
      end else if (i == 9) begin
        check("stream9.wr_en", wr_en, 1'b0);
      end
    end

    // Register-0 writes are swallowed; the following write lands one slot later.
    drive(1'b1, 5'd0, 32'h0000_0BAD, 1'b0, 5'd0, 32'h0);
    step();
    check("zp.e0.busy", busy, 32'h0);
    check("zp.e0.wr_en", wr_en, 1'b0);
    drive(1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 32'h0);
    step();
    check("zp.e1.wr_en", wr_en, 1'b0);
    check("zp.e1.busy", busy, 32'h0000_0200);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    check("zp.e2.wr_en", wr_en, 1'b1);
    check("zp.e2.wr_addr", wr_addr, 5'd9);
    check("zp.e2.busy", busy, 32'h0000_0200);
    step();
    check("zp.e3.wr_en", wr_en, 1'b0);
    check("zp.e3.busy", busy, 32'h0);

    // Build 2 entries in A and 1 in B, then pulse reset for part of a cycle.
    drive(1'b1, 5'd3, 32'h3333_3333, 1'b1, 5'd21, 32'h2121_2121);
    step();
    check_model("mid.e0");
    drive(1'b1, 5'd4, 32'h4444_4444, 1'b1, 5'd22, 32'h2222_2222);
    step();
    check_model("mid.e1");
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst.wr_en", wr_en, 1'b0);
    check("midrst.wr_addr", wr_addr, 5'd0);
    check("midrst.wr_data", wr_data, 32'h0);
    check("midrst.busy", busy, 32'h0);
    check("midrst.a_ready", a_ready, 1'b1);
    check("midrst.b_ready", b_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("postrst%0d.wr_en", i), wr_en, 1'b0);
      check($sformatf("postrst%0d.busy", i), busy, 32'h0);
    end

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, 5'($urandom), $urandom,
            ($urandom % 2) != 0, 5'($urandom), $urandom);
      step();
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the single register-file write port (RegWrite / Rd_Addr / Rd_Data) between two write-back requesters: A (ALU result path) and B (load/memory return path).
- Each requester has a valid/ready input FIFO.
- A round-robin arbiter drains one entry per cycle into a registered write stage that drives the RF directly.
- A 32-bit busy scoreboard tells the decode/hazard logic which registers still have writes pending.

Parameters:
DEPTH, 2, entries per requester FIFO; power of two, >= 2.
ZERO_PROTECT, 1, when 1, writes targeting register 0 are consumed but never issued to the RF.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
a_valid  input  1  requester A has a write.
a_ready  output  1  A FIFO can accept; equals !full_A.
a_addr  input  5  A destination register.
a_data  input  32  A write data.
b_valid  input  1  requester B has a write.
b_ready  output  1  B FIFO can accept; equals !full_B.
b_addr  input  5  B destination register.
b_data  input  32  B write data.
wr_en  output  1  registered; connects to RF RegWrite.
wr_addr  output  5  registered; connects to RF Rd_Addr.
wr_data  output  32  registered; connects to RF Rd_Data.
busy  output  32  bit i = 1 while any write to register i is pending.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset (rst_n=0, takes effect immediately without a clock edge):
  - both FIFOs empty; wr_en=0, wr_addr=0, wr_data=0; busy=0.
  - last_grant=B, so A wins the first conflict.
  - a_ready=b_ready=1.
  - valid inputs are ignored while rst_n=0.
- Reset mid-operation: all queued entries and the write stage are discarded; wr_en drops asynchronously. Nothing discarded is ever written after rst_n releases.
- Push: entry accepted at an edge where x_valid && x_ready.
  - ready depends only on current fullness. A full FIFO refuses a push even if it pops on the same edge (no pass-through).
- Pop/arbitration at every edge:
  - only A non-empty -> pop A.
  - only B non-empty -> pop B.
  - both non-empty -> pop the requester not in last_grant, then set last_grant to the winner.
  - last_grant is updated only on a conflict pop.
- Write stage at every edge:
  - if an entry is popped: wr_addr/wr_data <= head. wr_en <= 1, unless ZERO_PROTECT=1 and addr==0, in which case wr_en <= 0.
  - if nothing is popped: wr_en <= 0. wr_addr and wr_data hold their values.
- Latency: entry accepted at edge E0 is popped no earlier than E1; wr_en is high in the cycle after E1; the RF commits at E2. There is no input-to-output bypass.
- Throughput: at most one RF write per cycle. A lone requester streaming sees full rate.
- Ordering:
  - per-requester FIFO order is preserved.
  - no ordering is guaranteed between A and B. Same-address conflicts between A and B are the producer's responsibility.
- busy[i] = OR of:
  - any valid entry in FIFO A with addr==i;
  - any valid entry in FIFO B with addr==i;
  - (wr_en && wr_addr==i).
  - combinational from registered state.
  - busy[0] is forced to 0 when ZERO_PROTECT=1.
- FIFO pointers wrap modulo DEPTH. Occupancy counters are log2(DEPTH)+1 bits wide. full = (count==DEPTH); empty = (count==0).
- Simultaneous push and pop on the same FIFO in one edge: count is unchanged and both operations take effect.

Test Plan:
1. Assert rst_n=0 mid-cycle -> immediately wr_en=0, wr_addr=0, wr_data=0, busy=0, a_ready=b_ready=1.
2. Single A push (addr=5, data=0xDEADBEEF) at E0 ->
   - busy[5]=1 from after E0;
   - wr_en=1, wr_addr=5, wr_data=0xDEADBEEF for exactly one cycle after E1;
   - busy[5]=0 after E2.
3. A and B push every cycle from reset (A addr 1,2,3…; B addr 17,18,19…) ->
   - write sequence is 1,17,2,18,3,19;
   - a_ready and b_ready each drop once their FIFO holds DEPTH=2 entries;
   - no entry is lost or duplicated.
4. A alone streams 8 back-to-back writes -> wr_en high 8 consecutive cycles, in order, a_ready never deasserts.
5. ZERO_PROTECT=1: A pushes addr=0 then addr=9 ->
   - wr_en never asserts for addr 0;
   - addr 9 write appears one cycle after the addr-0 slot;
   - busy[0] stays 0.
6. Queue 2 entries in A and 1 in B, then pulse rst_n low for a half cycle -> wr_en=0 and busy=0 immediately; after release, wr_en stays 0 with no new pushes.
